// File: rtl/tt_um_serial_adder.sv
// Bit-serial two's-complement adder/subtractor: operands loaded byte-wise,
// sum formed LSB-first one bit per clock around a single carry flop.
module tt_um_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_result;
  logic [CNT_W-1:0] r_cnt;
  logic             r_c;
  logic             r_carry;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic             w_load_a;
  logic             w_load_b;
  logic             w_start;
  logic             w_sub;
  logic             w_accept;
  logic             w_start_go;
  logic             w_load_go;
  logic             w_run;
  logic             w_last;
  logic             w_s;
  logic             w_c_nxt;
  logic             w_unused;

  // Two chained half-adder cells form one full-adder bit slice.
  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (c & (a ^ b));
  endfunction

  assign w_load_a   = uio_in[0];
  assign w_load_b   = uio_in[1];
  assign w_start    = uio_in[2];
  assign w_sub      = uio_in[3];
  assign w_unused   = ^{uio_in[7:4], ui_in};

  assign w_accept   = (r_state != S_RUN);
  assign w_start_go = w_accept & w_start;
  assign w_load_go  = w_accept & ~w_start & (w_load_a | w_load_b);
  assign w_run      = (r_state == S_RUN);
  assign w_last     = w_run && (r_cnt == CNT_W'(WIDTH - 1));

  assign w_s        = fa_sum(r_sa[0], r_sb[0], r_c);
  assign w_c_nxt    = fa_carry(r_sa[0], r_sb[0], r_c);

  assign uo_out     = 8'(r_result);
  assign uio_out    = {r_busy, r_done, r_carry, r_ovf, 4'b0000};
  assign uio_oe     = 8'hE0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (w_start)                   w_state_nxt = S_RUN;
        else if (w_load_a | w_load_b)  w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opa    <= '0;
      r_opb    <= '0;
      r_sa     <= '0;
      r_sb     <= '0;
      r_sr     <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_c      <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (w_start_go) begin
      // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
      r_sa   <= r_opa;
      r_sb   <= r_opb ^ {WIDTH{w_sub}};
      r_c    <= w_sub;
      r_cnt  <= '0;
      r_busy <= 1'b1;
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_load_go) begin
      if (w_load_a) r_opa <= ui_in[WIDTH-1:0];
      if (w_load_b) r_opb <= ui_in[WIDTH-1:0];
      r_done <= 1'b0;
    end else if (w_run) begin
      r_c   <= w_c_nxt;
      r_sr  <= {w_s, r_sr[WIDTH-1:1]};
      r_sa  <= r_sa >> 1;
      r_sb  <= r_sb >> 1;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_ovf    <= r_c ^ w_c_nxt;
        r_result <= {w_s, r_sr[WIDTH-1:1]};
        r_carry  <= w_c_nxt;
        r_busy   <= 1'b0;
        r_done   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tt_um_serial_adder.sv
// Bench for tt_um_serial_adder: table-driven and random operations with a
// scoreboard queue, protocol corner cases, async reset, and a WIDTH=4 instance.
module tb_tt_um_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ui8, uio8, uo8, uioo8, oe8;
  logic [7:0] ui4, uio4, uo4, uioo4, oe4;

  tt_um_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .ui_in(ui8), .uo_out(uo8),
    .uio_in(uio8), .uio_out(uioo8), .uio_oe(oe8)
  );

  tt_um_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ui_in(ui4), .uo_out(uo4),
    .uio_in(uio4), .uio_out(uioo4), .uio_oe(oe4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    logic       carry;
    logic       ovf;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] res;
    logic       carry;
    logic       ovf;
  } vec_t;

  int         n_cmp = 0;
  int         n_fail = 0;
  exp_t       sbq[$];
  logic [7:0] prev_res[2];
  vec_t       tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit w4, input logic [7:0] d, input logic [7:0] c);
    if (w4) begin ui4 = d; uio4 = c; end
    else    begin ui8 = d; uio8 = c; end
  endtask

  function automatic logic [7:0] res_of(input bit w4);
    return w4 ? uo4 : uo8;
  endfunction

  function automatic logic [7:0] flags_of(input bit w4);
    return w4 ? uioo4 : uioo8;
  endfunction

  function automatic logic [7:0] oe_of(input bit w4);
    return w4 ? oe4 : oe8;
  endfunction

  // Reference: plain integer arithmetic with the textbook sign-overflow rule.
  function automatic exp_t model(input bit w4, input logic [7:0] a, input logic [7:0] b,
                                 input logic sub);
    exp_t       e;
    int         w;
    logic [8:0] m, aa, bb, s;
    w  = w4 ? 4 : 8;
    m  = (9'd1 << w) - 9'd1;
    aa = {1'b0, a} & m;
    bb = (sub ? ~{1'b0, b} : {1'b0, b}) & m;
    s  = aa + bb + 9'(sub);
    e.res   = s[7:0] & m[7:0];
    e.carry = s[w];
    e.ovf   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
    return e;
  endfunction

  task automatic cycle(input bit w4, input logic [7:0] d, input logic [7:0] c);
    @(negedge clk);
    drive(w4, d, c);
  endtask

  // Issue a start (ctl/data held for one edge), then wait for done and score.
  task automatic exec(input bit w4, input logic [7:0] ctl, input logic [7:0] data,
                      input bit noise, input string nm);
    int         lat;
    logic [7:0] f;
    exp_t       e;
    @(negedge clk);
    drive(w4, data, ctl);
    @(negedge clk);
    drive(w4, 8'h00, 8'h00);
    f = flags_of(w4);
    chk({nm, " busy@start"}, 32'(f[7]), 32'd1);
    chk({nm, " done@start"}, 32'(f[6]), 32'd0);
    chk({nm, " hold"}, 32'(res_of(w4)), 32'(prev_res[w4]));
    chk({nm, " oe"}, 32'(oe_of(w4)), 32'hE0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (noise && lat == 2) drive(w4, 8'hAA, 8'h0F);
      if (noise && lat == 3) drive(w4, 8'h00, 8'h00);
      f = flags_of(w4);
    end while (!f[6] && lat < 20);
    chk({nm, " latency"}, 32'(lat), w4 ? 32'd4 : 32'd8);
    if (sbq.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %0h expected an entry", nm, res_of(w4));
    end else begin
      e = sbq.pop_front();
      chk({nm, " result"}, 32'(res_of(w4)), 32'(e.res));
      chk({nm, " carry"}, 32'(f[5]), 32'(e.carry));
      chk({nm, " ovf"}, 32'(f[4]), 32'(e.ovf));
      chk({nm, " busy@done"}, 32'(f[7]), 32'd0);
      prev_res[w4] = e.res;
    end
  endtask

  task automatic op(input bit w4, input logic [7:0] a, input logic [7:0] b,
                    input logic sub, input exp_t e, input string nm);
    cycle(w4, a, 8'h01);
    cycle(w4, b, 8'h02);
    sbq.push_back(e);
    exec(w4, {4'b0000, sub, 3'b100}, 8'h00, 1'b0, nm);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time %0t reached, expected completion earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    logic       rs;
    exp_t       e;

    tbl[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[3] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
    tbl[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[5] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[7] = '{8'h50, 8'hB0, 1'b1, 8'hA0, 1'b0, 1'b1};
    prev_res[0] = 8'h00;
    prev_res[1] = 8'h00;

    // Reset with random inputs on both instances
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b0, 8'($urandom), 8'($urandom));
      drive(1'b1, 8'($urandom), 8'($urandom));
    end
    #1;
    chk("rst uo8", 32'(uo8), 32'h00);
    chk("rst uio8", 32'(uioo8), 32'h00);
    chk("rst oe8", 32'(oe8), 32'hE0);
    chk("rst uo4", 32'(uo4), 32'h00);
    chk("rst uio4", 32'(uioo4), 32'h00);
    chk("rst oe4", 32'(oe4), 32'hE0);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00);
    drive(1'b1, 8'h00, 8'h00);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle uo8", 32'(uo8), 32'h00);
    chk("idle uio8", 32'(uioo8), 32'h00);

    for (int i = 0; i < 8; i++) begin
      e = '{tbl[i].res, tbl[i].carry, tbl[i].ovf};
      op(1'b0, tbl[i].a, tbl[i].b, tbl[i].sub, e, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      op(1'b0, ra, rb, rs, model(1'b0, ra, rb, rs), $sformatf("rnd%0d", i));
    end

    // Inputs toggled during RUN are ignored; restart from DONE reuses operands
    op(1'b0, 8'h12, 8'h34, 1'b0, '{8'h46, 1'b0, 1'b0}, "pre-noise");
    sbq.push_back('{8'h46, 1'b0, 1'b0});
    exec(1'b0, 8'h04, 8'h00, 1'b1, "noise");
    sbq.push_back('{8'h46, 1'b0, 1'b0});
    exec(1'b0, 8'h04, 8'h00, 1'b0, "reuse");

    // Both loads in one cycle
    cycle(1'b0, 8'h11, 8'h03);
    sbq.push_back('{8'h22, 1'b0, 1'b0});
    exec(1'b0, 8'h04, 8'h00, 1'b0, "dual-load");

    // Load from DONE returns to IDLE, clearing done
    cycle(1'b0, 8'h05, 8'h01);
    cycle(1'b0, 8'h03, 8'h02);
    cycle(1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk("load clears done", 32'(uioo8[6]), 32'd0);
    // load_a with start in IDLE: the load is dropped
    sbq.push_back('{8'h08, 1'b0, 1'b0});
    exec(1'b0, 8'h05, 8'h70, 1'b0, "start+load idle");
    // loads with start in DONE: start wins
    sbq.push_back('{8'h08, 1'b0, 1'b0});
    exec(1'b0, 8'h07, 8'h99, 1'b0, "start+load done");

    // Asynchronous reset in the middle of an operation
    cycle(1'b0, 8'h00, 8'h04);
    cycle(1'b0, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst uo8", 32'(uo8), 32'h00);
    chk("midrst uio8", 32'(uioo8), 32'h00);
    chk("midrst oe8", 32'(oe8), 32'hE0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_res[0] = 8'h00;
    prev_res[1] = 8'h00;
    repeat (12) @(negedge clk);
    chk("post-rst no done", 32'(uioo8[6]), 32'd0);
    chk("post-rst no busy", 32'(uioo8[7]), 32'd0);
    op(1'b0, 8'h01, 8'h02, 1'b0, '{8'h03, 1'b0, 1'b0}, "after-rst");

    // WIDTH=4 instance; upper operand bits must be ignored
    op(1'b1, 8'hFF, 8'hF1, 1'b0, '{8'h00, 1'b1, 1'b0}, "w4 F+1");
    op(1'b1, 8'h07, 8'h01, 1'b0, '{8'h08, 1'b0, 1'b1}, "w4 7+1");
    op(1'b1, 8'hA3, 8'h55, 1'b1, '{8'h0E, 1'b0, 1'b0}, "w4 3-5");
    for (int i = 0; i < 3; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      op(1'b1, ra, rb, rs, model(1'b1, ra, rb, rs), $sformatf("w4 rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
